// File: rtl/rom_loader_sram_writer.sv
`default_nettype none
// ============================================================================
// Module : rom_loader_sram_writer
// Brief  : Accepts 16-bit instruction words from a ROM loader handshake and
//          writes each one into a quad-SPI serial SRAM. After reset the SRAM
//          is switched into quad mode with a single-wire 0x38 command.
// Rev    : 1.0  initial release
// ============================================================================
module rom_loader_sram_writer #(
  parameter int          ROM_ADDRESS_WIDTH = 16,
  parameter logic [23:0] BASE_ADDRESS      = 24'h000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rom_loader_load,
  input  logic                         rom_loader_sck,
  input  logic [15:0]                  rom_loader_data,
  output logic                         rom_loader_ack,
  output logic                         busy,
  output logic [ROM_ADDRESS_WIDTH-1:0] word_count,
  output logic                         rom_cs_n,
  output logic                         rom_sck,
  output logic                         rom_sio_oe,
  output logic                         rom_sio0_o,
  output logic                         rom_sio1_o,
  output logic                         rom_sio2_o,
  output logic                         rom_sio3_o,
  input  logic                         rom_sio0_i,
  input  logic                         rom_sio1_i,
  input  logic                         rom_sio2_i,
  input  logic                         rom_sio3_i
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [2:0] S_ACK  = 3'd6;

  localparam logic [7:0] QUAD_ENTER_CMD = 8'h38;
  localparam logic [7:0] QUAD_WRITE_CMD = 8'h02;

  // INIT timeline: count 0 is a cs_n-high settle cycle right after reset,
  // counts 1..16 carry the 8 command bits, count 17 is the trailing gap.
  localparam logic [4:0] INIT_LAST = 5'd17;
  // Frame timeline: one counter spans CMD (0..3), ADDR (4..15), DATA (16..23).
  localparam logic [4:0] CMD_LAST  = 5'd3;
  localparam logic [4:0] ADDR_LAST = 5'd15;
  localparam logic [4:0] DATA_LAST = 5'd23;

  logic [2:0]                   state_q, state_d;
  logic [4:0]                   cnt_q, cnt_d;
  logic [47:0]                  frame_q, frame_d;
  logic [ROM_ADDRESS_WIDTH-1:0] word_count_q, word_count_d;
  logic                         sck_q;

  logic                         sck_rise;
  logic [23:0]                  wc24;
  logic [23:0]                  byte_addr;
  logic [3:0]                   init_phase;
  logic [5:0]                   nib_msb;
  logic [3:0]                   nibble;
  logic                         unused_sio_in;

  // SIO inputs exist only for pin compatibility with the SRAM footprint.
  assign unused_sio_in = &{rom_sio0_i, rom_sio1_i, rom_sio2_i, rom_sio3_i};

  // Word index extended or truncated to the 24-bit SRAM address space.
  generate
    if (ROM_ADDRESS_WIDTH >= 24) begin : g_wc_trunc
      assign wc24 = word_count_q[23:0];
    end else begin : g_wc_ext
      assign wc24 = {{(24-ROM_ADDRESS_WIDTH){1'b0}}, word_count_q};
    end
  endgenerate

  // Byte address wraps naturally modulo 2^24.
  assign byte_addr  = BASE_ADDRESS + {wc24[22:0], 1'b0};
  assign sck_rise   = rom_loader_sck & ~sck_q;
  assign init_phase = cnt_q[3:0] - 4'd1;
  assign nib_msb    = 6'd47 - {cnt_q[4:1], 2'b00};
  assign nibble     = frame_q[nib_msb -: 4];
  assign word_count = word_count_q;

  // State, counters, captured frame and loader-strobe history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_INIT;
      cnt_q        <= 5'd0;
      frame_q      <= 48'd0;
      word_count_q <= '0;
      sck_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      word_count_q <= word_count_d;
      sck_q        <= rom_loader_sck;
    end
  end

  // Sequencing: edges are only honoured in IDLE, so anything offered while
  // busy is consumed by the edge register and never queued.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    word_count_d = word_count_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_IDLE: begin
        if (!rom_loader_load) begin
          word_count_d = '0;
        end else if (sck_rise) begin
          frame_d = {QUAD_WRITE_CMD, byte_addr, rom_loader_data};
          state_d = S_CMD;
          cnt_d   = 5'd0;
        end
      end
      S_CMD: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CMD_LAST) state_d = S_ADDR;
      end
      S_ADDR: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ADDR_LAST) state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_GAP;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_GAP: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        word_count_d = word_count_q + ROM_ADDRESS_WIDTH'(1);
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Pin drive decoded from state; sck is high on the odd cycle of each bit
  // or nibble so data is always stable before the rising serial clock.
  always_comb begin
    rom_cs_n       = 1'b1;
    rom_sck        = 1'b0;
    rom_sio_oe     = 1'b0;
    rom_sio0_o     = 1'b0;
    rom_sio1_o     = 1'b0;
    rom_sio2_o     = 1'b0;
    rom_sio3_o     = 1'b0;
    rom_loader_ack = 1'b0;
    busy           = 1'b1;
    case (state_q)
      S_INIT: begin
        if ((cnt_q != 5'd0) && (cnt_q != INIT_LAST)) begin
          rom_cs_n   = 1'b0;
          rom_sio_oe = 1'b1;
          rom_sck    = init_phase[0];
          rom_sio0_o = QUAD_ENTER_CMD[3'd7 - init_phase[3:1]];
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        rom_cs_n   = 1'b0;
        rom_sio_oe = 1'b1;
        rom_sck    = cnt_q[0];
        {rom_sio3_o, rom_sio2_o, rom_sio1_o, rom_sio0_o} = nibble;
      end
      S_IDLE: begin
        busy = 1'b0;
      end
      S_ACK: begin
        busy           = 1'b0;
        rom_loader_ack = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader_sram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_rom_loader_sram_writer
// Brief  : Directed bench with a serial-SRAM pin monitor; a second instance
//          with a 2-bit word index exercises counter/address wrap.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rom_loader_sram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic        lsck;
  logic [15:0] ldata;

  always #5 clk = ~clk;

  // Main instance (default parameters)
  wire        ack, busy, cs_n, sck, oe, s0, s1, s2, s3;
  wire [15:0] wc;
  // Narrow instance (2-bit word index)
  wire        b_ack, b_busy, b_cs_n, b_sck, b_oe, b0, b1, b2, b3;
  wire [1:0]  b_wc;

  rom_loader_sram_writer dut (
    .clk(clk), .reset_n(reset_n), .rom_loader_load(load), .rom_loader_sck(lsck),
    .rom_loader_data(ldata), .rom_loader_ack(ack), .busy(busy), .word_count(wc),
    .rom_cs_n(cs_n), .rom_sck(sck), .rom_sio_oe(oe),
    .rom_sio0_o(s0), .rom_sio1_o(s1), .rom_sio2_o(s2), .rom_sio3_o(s3),
    .rom_sio0_i(1'b0), .rom_sio1_i(1'b0), .rom_sio2_i(1'b0), .rom_sio3_i(1'b0)
  );

  rom_loader_sram_writer #(.ROM_ADDRESS_WIDTH(2), .BASE_ADDRESS(24'h000000)) dut_b (
    .clk(clk), .reset_n(reset_n), .rom_loader_load(load), .rom_loader_sck(lsck),
    .rom_loader_data(ldata), .rom_loader_ack(b_ack), .busy(b_busy), .word_count(b_wc),
    .rom_cs_n(b_cs_n), .rom_sck(b_sck), .rom_sio_oe(b_oe),
    .rom_sio0_o(b0), .rom_sio1_o(b1), .rom_sio2_o(b2), .rom_sio3_o(b3),
    .rom_sio0_i(1'b0), .rom_sio1_i(1'b0), .rom_sio2_i(1'b0), .rom_sio3_i(1'b0)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM pin monitor (main instance) ----------------
  int          cyc = 0;
  logic [47:0] cur_nib = '0, last_frame = '0;
  logic [7:0]  cur_bits = '0, last_bits = '0;
  int          nibs = 0, last_nibs = 0, cs_len = 0, last_cs_len = 0;
  int          frames = 0, first_cs_cyc = 0, ack_cnt = 0, ack_cyc = 0, pin_err = 0;
  logic        prev_cs = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      cur_nib = '0; cur_bits = '0; nibs = 0; cs_len = 0; prev_cs = 1'b1;
    end else begin
      if ((oe !== ~cs_n) || (cs_n && sck)) pin_err++;
      if (!cs_n) begin
        if (prev_cs) first_cs_cyc = cyc;
        cs_len++;
        if (sck) begin
          cur_nib  = {cur_nib[43:0], s3, s2, s1, s0};
          cur_bits = {cur_bits[6:0], s0};
          nibs++;
        end
      end else if (!prev_cs) begin
        last_frame = cur_nib; last_bits = cur_bits; last_nibs = nibs;
        last_cs_len = cs_len; frames++;
        cur_nib = '0; cur_bits = '0; nibs = 0; cs_len = 0;
      end
      if (ack) begin ack_cnt++; ack_cyc = cyc; end
      prev_cs = cs_n;
    end
  end

  // ---------------- Frame capture (narrow instance) ----------------
  logic [47:0] b_cur = '0, b_last = '0;
  logic        b_prev = 1'b1;

  always @(negedge clk) begin
    if (!reset_n) begin
      b_prev = 1'b1;
    end else begin
      if (!b_cs_n && b_sck) b_cur = {b_cur[43:0], b3, b2, b1, b0};
      else if (b_cs_n && !b_prev) b_last = b_cur;
      b_prev = b_cs_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Offer one word, optionally drop load after drop_at cycles, wait for ack.
  task automatic send_word(input logic [15:0] w, input int drop_at, input string tag, output int t_edge);
    int a0;
    a0 = ack_cnt;
    tick(1);
    ldata  = w;
    lsck   = 1'b1;
    t_edge = cyc;
    for (int i = 0; i < 40; i++) begin
      if (ack_cnt != a0) break;
      if (i == drop_at) load = 1'b0;
      tick(1);
    end
    chk({tag, "_ack"}, 64'(ack_cnt - a0), 64'd1);
    lsck = 1'b0;
    tick(2);
  endtask

  task automatic wait_init(input string tag);
    int f0;
    f0 = frames;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick(1);
    end
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    chk({tag, "_frames"},    64'(frames - f0), 64'd1);
    chk({tag, "_cmd38"},     64'(last_bits), 64'h38);
    chk({tag, "_bits"},      64'(last_nibs), 64'd8);
    chk({tag, "_cs_len"},    64'(last_cs_len), 64'd16);
  endtask

  logic [47:0] exp3 [3];
  int t, a0, f0;

  initial begin
    exp3[0] = 48'h02_000000_0001;
    exp3[1] = 48'h02_000002_0002;
    exp3[2] = 48'h02_000004_0003;

    reset_n = 1'b0; load = 1'b0; lsck = 1'b0; ldata = 16'h0000;
    tick(3);
    chk("reset_pins", {55'd0, cs_n, sck, oe, s3, s2, s1, s0, ack, busy}, {55'd0, 9'b1_0_0_0000_0_1});
    chk("reset_wc", 64'(wc), 64'd0);

    // Quad-mode entry after reset release
    reset_n = 1'b1;
    wait_init("init");
    chk("init_wc", 64'(wc), 64'd0);

    // Single word with exact latency
    load = 1'b1;
    tick(1);
    send_word(16'hABCD, -1, "abcd", t);
    chk("abcd_frame", 64'(last_frame), 64'h02_000000_ABCD);
    chk("abcd_cs_len", 64'(last_cs_len), 64'd24);
    chk("abcd_cs_start", 64'(first_cs_cyc - t), 64'd1);
    chk("abcd_ack_lat", 64'(ack_cyc - t), 64'd26);
    chk("abcd_wc", 64'(wc), 64'd1);
    chk("abcd_busy", 64'(busy), 64'd0);
    load = 1'b0;
    tick(2);
    chk("abcd_clear", 64'(wc), 64'd0);

    // Three-word session, consecutive addresses
    load = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      send_word(16'(i + 1), -1, "seq", t);
      chk("seq_frame", 64'(last_frame), 64'(exp3[i]));
    end
    chk("seq_wc", 64'(wc), 64'd3);
    load = 1'b0;
    tick(2);
    chk("seq_clear", 64'(wc), 64'd0);

    // Second edge offered while busy is dropped
    load = 1'b1;
    tick(1);
    a0 = ack_cnt; f0 = frames;
    ldata = 16'h1234; lsck = 1'b1;
    tick(5);
    lsck = 1'b0;
    tick(2);
    ldata = 16'h5555; lsck = 1'b1;
    tick(40);
    chk("busy_ign_acks", 64'(ack_cnt - a0), 64'd1);
    chk("busy_ign_frames", 64'(frames - f0), 64'd1);
    chk("busy_ign_frame", 64'(last_frame), 64'h02_000000_1234);
    chk("busy_ign_wc", 64'(wc), 64'd1);
    lsck = 1'b0;
    tick(2);

    // Load falls mid-frame: frame completes and acks, then count clears
    send_word(16'h00FF, 10, "midfall", t);
    chk("midfall_frame", 64'(last_frame), 64'h02_000002_00FF);
    chk("midfall_wc", 64'(wc), 64'd0);

    // Edge coincident with load fall is ignored
    load = 1'b1;
    tick(1);
    a0 = ack_cnt; f0 = frames;
    load = 1'b0; lsck = 1'b1; ldata = 16'hDEAD;
    tick(35);
    chk("coinc_acks", 64'(ack_cnt - a0), 64'd0);
    chk("coinc_frames", 64'(frames - f0), 64'd0);
    lsck = 1'b0;
    tick(2);

    // Word index wrap on the 2-bit instance
    load = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) send_word(16'h0010 + 16'(i), -1, "wrap", t);
    chk("wrap_b_wc", 64'(b_wc), 64'd1);
    chk("wrap_b_frame", 64'(b_last), 64'h02_000000_0014);
    chk("wrap_a_wc", 64'(wc), 64'd5);
    chk("wrap_a_frame", 64'(last_frame), 64'h02_000008_0014);

    // Reset during DATA aborts immediately, no ack, INIT repeats
    a0 = ack_cnt;
    tick(1);
    ldata = 16'hBEEF; lsck = 1'b1;
    tick(20);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_pins", {61'd0, cs_n, oe, sck}, {61'd0, 3'b100});
    lsck = 1'b0;
    tick(2);
    reset_n = 1'b1;
    wait_init("reinit");
    chk("abort_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("abort_wc", 64'(wc), 64'd0);
    chk("pin_rules", 64'(pin_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_loader_sram_writer.md
ROM_LOADER_SRAM_WRITER -- requirements
Module: rom_loader_sram_writer

Interface
REQ-001 SHALL have parameter ROM_ADDRESS_WIDTH, default 16: width of the word index; the byte address is the word index times 2.
REQ-002 SHALL have parameter BASE_ADDRESS, default 24'h000000: byte address of ROM word 0 in the SRAM.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-005 rom_loader_load  input  1  loading session active; hack CPU held in reset by upstream while high.
REQ-006 rom_loader_sck  input  1  word-valid level; a 0->1 transition offers rom_loader_data.
REQ-007 rom_loader_data  input  16  instruction word, MSB first on the wire.
REQ-008 rom_loader_ack  output  1  one-cycle pulse: offered word written to SRAM.
REQ-009 busy  output  1  high from word capture (or init) until ack/init done.
REQ-010 word_count  output  ROM_ADDRESS_WIDTH  words written in the current session.
REQ-011 rom_cs_n, rom_sck, rom_sio_oe  output  1 each  serial SRAM chip select, serial clock, SIO output enable.
REQ-012 rom_sio0_o..rom_sio3_o  output  1 each  SIO drive values; rom_sio0_i..rom_sio3_i  input  1 each  unused, present for pin compatibility.

Function
REQ-013 States SHALL be INIT, IDLE, CMD, ADDR, DATA, GAP, ACK.
REQ-014 INIT (entered after reset release) SHALL send byte 0x38 (enter quad mode) SPI-style on rom_sio0_o only, MSB first, 8 bits, 2 clk per bit; rom_sio_oe=1; rom_cs_n low for exactly 16 cycles; then 1 cycle cs_n high, then IDLE.
REQ-015 Serial clock SHALL be clk/2: data changes while rom_sck=0, rom_sck=1 on the second cycle of each bit/nibble; rom_sck=0 whenever rom_cs_n=1.
REQ-016 In IDLE, a registered 0->1 edge of rom_loader_sck while rom_loader_load=1 SHALL capture rom_loader_data and the address, and enter CMD the next cycle.
REQ-017 An edge with rom_loader_load=0, or any edge while not in IDLE, SHALL be ignored (not queued).
REQ-018 Quad write frame SHALL be: CMD 2 nibbles of 0x02; ADDR 6 nibbles of the 24-bit byte address BASE_ADDRESS + 2*word_count; DATA 4 nibbles of the captured word; all MSB nibble first on sio3..sio0.
REQ-019 rom_cs_n SHALL be low for exactly 24 clk cycles per word; rom_sio_oe=1 while cs_n low, 0 otherwise.
REQ-020 GAP SHALL hold cs_n high for 1 cycle; ACK SHALL pulse rom_loader_ack for exactly 1 cycle, increment word_count, and return to IDLE.
REQ-021 Latency: capture edge registered at cycle T -> cs_n low T+1..T+24 -> ack at T+26.
REQ-022 word_count SHALL wrap from 2^ROM_ADDRESS_WIDTH-1 to 0; address arithmetic SHALL be 24-bit modulo 2^24.
REQ-023 word_count SHALL clear to 0 on any cycle where rom_loader_load=0 and state is IDLE; a load fall mid-frame SHALL let the frame complete and ack, then clear.
REQ-024 If a sck edge and a load fall occur in the same cycle, the edge SHALL be ignored.
REQ-025 busy SHALL be 1 in INIT, CMD, ADDR, DATA, GAP, and 0 in IDLE and ACK.

Reset
REQ-026 While reset_n=0 (asynchronously): rom_cs_n=1, rom_sck=0, rom_sio_oe=0, rom_sio*_o=0, rom_loader_ack=0, word_count=0, busy=1, state INIT, sck edge detector cleared to 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately with no ack; INIT SHALL re-run after release.

Verification
REQ-028 Reset release -> 0x38 seen on sio0 over 8 rising rom_sck edges, cs_n low 16 cycles, busy falls after.
REQ-029 load=1, sck 0->1 with data 16'hABCD -> SRAM model captures nibbles 0,2,0,0,0,0,0,0,A,B,C,D; ack pulse 26 cycles after edge; word_count=1.
REQ-030 Three words 16'h0001,16'h0002,16'h0003 with full handshakes -> addresses 0x000000, 0x000002, 0x000004; word_count=3; load low -> word_count=0.
REQ-031 Second sck edge offered while busy -> ignored, single write, single ack.
REQ-032 ROM_ADDRESS_WIDTH=2, 5 words -> fifth write at byte address 0x000000, word_count=1.
REQ-033 reset_n low during DATA -> cs_n=1 and oe=0 in the same cycle, no ack, INIT repeats.
